// File: rtl/cache_controller_pkg.sv
// Shared constants for the data cache: geometry, address field positions,
// controller state encodings and a block word-select helper.
// Latency: n/a (constants only). Backpressure: n/a.
package cache_controller_pkg;

  localparam int CACHE_ADDRESS_LEN = 32;
  localparam int CACHE_DATA_LEN    = 32;
  localparam int CACHE_SET_COUNT   = 64;
  localparam int CACHE_TAG_LEN     = 10;
  localparam int CACHE_INDEX_LEN   = 6;

  // Byte address layout: [18:9] tag, [8:3] set index, [2] word in block.
  localparam int CACHE_WORD_SEL_BIT = 2;
  localparam int CACHE_INDEX_LSB    = 3;
  localparam int CACHE_INDEX_MSB    = 8;
  localparam int CACHE_TAG_LSB      = 9;
  localparam int CACHE_TAG_MSB      = 18;

  localparam logic [1:0] CACHE_IDLE      = 2'd0;
  localparam logic [1:0] CACHE_READ_MISS = 2'd1;
  localparam logic [1:0] CACHE_WRITE     = 2'd2;

  // Word 0 lives in the low half of a block, word 1 in the high half.
  function automatic logic [CACHE_DATA_LEN-1:0] select_word(
    input logic [2*CACHE_DATA_LEN-1:0] blk,
    input logic                        sel
  );
    return sel ? blk[2*CACHE_DATA_LEN-1:CACHE_DATA_LEN] : blk[CACHE_DATA_LEN-1:0];
  endfunction

endpackage

// File: rtl/cache_memory.sv
// 2-way cache storage: valid/tag/block arrays per way plus one LRU bit per set,
// combinational hit lookup, block fill into the LRU way, word write into the hit way.
// Latency: lookup same cycle, updates at the clock edge. Backpressure: none.
// Ports: clk_i/rst_ni; index_i/tag_i/word_sel_i select the set and word;
//        hit_o/hit_word_o lookup result; touch_i marks the hit way most recent;
//        word_write_i/word_data_i overwrite the hit word; fill_i/fill_block_i
//        install a block (tag_i) into the LRU way.
module cache_memory
  import cache_controller_pkg::*;
#(
  parameter int SET_COUNT = CACHE_SET_COUNT,
  parameter int TAG_LEN   = CACHE_TAG_LEN,
  parameter int DATA_LEN  = CACHE_DATA_LEN,
  localparam int INDEX_LEN = $clog2(SET_COUNT)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [INDEX_LEN-1:0]  index_i,
  input  logic [TAG_LEN-1:0]    tag_i,
  input  logic                  word_sel_i,
  output logic                  hit_o,
  output logic [DATA_LEN-1:0]   hit_word_o,
  input  logic                  touch_i,
  input  logic                  word_write_i,
  input  logic [DATA_LEN-1:0]   word_data_i,
  input  logic                  fill_i,
  input  logic [2*DATA_LEN-1:0] fill_block_i
);

  logic                  valid_q [2][SET_COUNT];
  logic [TAG_LEN-1:0]    tag_q   [2][SET_COUNT];
  logic [2*DATA_LEN-1:0] data_q  [2][SET_COUNT];
  // lru_q[s] names the least recently used way of set s.
  logic [SET_COUNT-1:0]  lru_q;

  logic hit_way0, hit_way1, hit_way, fill_way;

  assign hit_way0   = valid_q[0][index_i] && (tag_q[0][index_i] == tag_i);
  assign hit_way1   = valid_q[1][index_i] && (tag_q[1][index_i] == tag_i);
  assign hit_o      = hit_way0 | hit_way1;
  assign hit_way    = hit_way1 & ~hit_way0;
  assign fill_way   = lru_q[index_i];
  assign hit_word_o = select_word(data_q[hit_way][index_i], word_sel_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SET_COUNT; s++) begin
        valid_q[0][s] <= 1'b0;
        valid_q[1][s] <= 1'b0;
      end
      lru_q <= '0;
    end else if (fill_i) begin
      valid_q[fill_way][index_i] <= 1'b1;
      lru_q[index_i]             <= ~fill_way;
    end else if (touch_i && hit_o) begin
      lru_q[index_i] <= ~hit_way;
    end
  end

  // Tag/data contents are meaningless until valid is set, so no reset here.
  always_ff @(posedge clk_i) begin
    if (fill_i) begin
      tag_q[fill_way][index_i]  <= tag_i;
      data_q[fill_way][index_i] <= fill_block_i;
    end else if (word_write_i && hit_o) begin
      if (word_sel_i) begin
        data_q[hit_way][index_i][DATA_LEN +: DATA_LEN] <= word_data_i;
      end else begin
        data_q[hit_way][index_i][0 +: DATA_LEN] <= word_data_i;
      end
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way write-through, no-write-allocate data cache between memory stage and SRAM controller.
// Latency: read hit 0 cycles (same-cycle ready); read miss and every write wait for sram_ready.
// Backpressure: ready=0 freezes the pipeline; SRAM requests held until sram_ready=1.
// Ports: clk/rst (async active-low); address/write_data/read_en/write_en/read_data/ready
//        to the memory stage; sram_* handshake and data to the SRAM controller.
module cache_controller
  import cache_controller_pkg::*;
#(
  parameter int ADDRESS_LEN = CACHE_ADDRESS_LEN,
  parameter int DATA_LEN    = CACHE_DATA_LEN,
  parameter int SET_COUNT   = CACHE_SET_COUNT,
  parameter int TAG_LEN     = CACHE_TAG_LEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDRESS_LEN-1:0] address,
  input  logic [DATA_LEN-1:0]    write_data,
  input  logic                   read_en,
  input  logic                   write_en,
  output logic [DATA_LEN-1:0]    read_data,
  output logic                   ready,
  output logic [ADDRESS_LEN-1:0] sram_address,
  output logic [DATA_LEN-1:0]    sram_write_data,
  input  logic [2*DATA_LEN-1:0]  sram_read_data,
  output logic                   sram_write_en,
  output logic                   sram_read_en,
  input  logic                   sram_ready
);

  logic [1:0]             state_q, state_d;
  logic [ADDRESS_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0]    wdata_q, wdata_d;

  logic                   in_idle;
  logic                   hit;
  logic [DATA_LEN-1:0]    hit_word;
  logic                   touch, word_write, fill;

  // While a request is outstanding the lookup uses the latched address so a
  // fill lands in the set that missed.
  assign in_idle = (state_q == CACHE_IDLE);

  cache_memory #(
    .SET_COUNT (SET_COUNT),
    .TAG_LEN   (TAG_LEN),
    .DATA_LEN  (DATA_LEN)
  ) u_mem (
    .clk_i        (clk),
    .rst_ni       (rst),
    .index_i      (in_idle ? address[CACHE_INDEX_MSB:CACHE_INDEX_LSB]
                           : addr_q[CACHE_INDEX_MSB:CACHE_INDEX_LSB]),
    .tag_i        (in_idle ? address[CACHE_TAG_MSB:CACHE_TAG_LSB]
                           : addr_q[CACHE_TAG_MSB:CACHE_TAG_LSB]),
    .word_sel_i   (in_idle ? address[CACHE_WORD_SEL_BIT] : addr_q[CACHE_WORD_SEL_BIT]),
    .hit_o        (hit),
    .hit_word_o   (hit_word),
    .touch_i      (touch),
    .word_write_i (word_write),
    .word_data_i  (write_data),
    .fill_i       (fill),
    .fill_block_i (sram_read_data)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    ready           = 1'b0;
    read_data       = '0;
    sram_address    = '0;
    sram_write_data = '0;
    sram_read_en    = 1'b0;
    sram_write_en   = 1'b0;
    touch           = 1'b0;
    word_write      = 1'b0;
    fill            = 1'b0;

    // Outputs are forced quiet while reset is held, even if a request is up.
    if (!rst) begin
      ready = 1'b1;
    end else begin
      case (state_q)
        CACHE_IDLE: begin
          // A simultaneous read and write is served as a read.
          if (read_en) begin
            if (hit) begin
              ready     = 1'b1;
              read_data = hit_word;
              touch     = 1'b1;
            end else begin
              addr_d       = address;
              sram_read_en = 1'b1;
              sram_address = {address[ADDRESS_LEN-1:3], 3'b000};
              state_d      = CACHE_READ_MISS;
            end
          end else if (write_en) begin
            addr_d          = address;
            wdata_d         = write_data;
            sram_write_en   = 1'b1;
            sram_address    = address;
            sram_write_data = write_data;
            word_write      = 1'b1;
            touch           = 1'b1;
            state_d         = CACHE_WRITE;
          end else begin
            ready = 1'b1;
          end
        end
        CACHE_READ_MISS: begin
          sram_read_en = 1'b1;
          sram_address = {addr_q[ADDRESS_LEN-1:3], 3'b000};
          if (sram_ready) begin
            ready     = 1'b1;
            read_data = select_word(sram_read_data, addr_q[CACHE_WORD_SEL_BIT]);
            fill      = 1'b1;
            state_d   = CACHE_IDLE;
          end
        end
        CACHE_WRITE: begin
          sram_write_en   = 1'b1;
          sram_address    = addr_q;
          sram_write_data = wdata_q;
          if (sram_ready) begin
            ready   = 1'b1;
            state_d = CACHE_IDLE;
          end
        end
        default: state_d = CACHE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CACHE_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: SRAM responder with fixed latency, a cache model
// checked against the DUT every cycle, and directed requests with literal results.
// Latency/backpressure: SRAM completes 4 cycles after the issuing cycle.
module tb_cache_controller;

  localparam int SRAM_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        read_en = 1'b0;
  logic        write_en = 1'b0;
  logic [31:0] read_data;
  logic        ready;
  logic [31:0] sram_address;
  logic [31:0] sram_write_data;
  logic [63:0] sram_read_data = '0;
  logic        sram_write_en;
  logic        sram_read_en;
  logic        sram_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_controller dut (
    .clk             (clk),
    .rst             (rst),
    .address         (address),
    .write_data      (write_data),
    .read_en         (read_en),
    .write_en        (write_en),
    .read_data       (read_data),
    .ready           (ready),
    .sram_address    (sram_address),
    .sram_write_data (sram_write_data),
    .sram_read_data  (sram_read_data),
    .sram_write_en   (sram_write_en),
    .sram_read_en    (sram_read_en),
    .sram_ready      (sram_ready)
  );

  // ---------------- SRAM responder ----------------
  logic [63:0] sram_mem [int unsigned];
  int          sram_cnt = 0;

  function automatic logic [63:0] sram_peek(input logic [31:0] a);
    int unsigned key;
    key = a >> 3;
    if (sram_mem.exists(key)) return sram_mem[key];
    if (key == 32'h80) return 64'hBBBBBBBB_AAAAAAAA;
    return {32'hF000_0000 | key, 32'h0F00_0000 | key};
  endfunction

  always begin
    logic [63:0] blk;
    @(posedge clk);
    #2;
    if (sram_ready) sram_cnt = 0;
    if (!rst || !(sram_read_en || sram_write_en)) sram_cnt = 0;
    else sram_cnt++;
    sram_ready     = (sram_cnt == SRAM_LAT + 1);
    sram_read_data = sram_peek(sram_address);
    if (sram_ready && sram_write_en) begin
      blk = sram_peek(sram_address);
      if (sram_address[2]) blk[63:32] = sram_write_data;
      else blk[31:0] = sram_write_data;
      sram_mem[sram_address >> 3] = blk;
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- cache model ----------------
  logic        mv  [64][2];
  logic [9:0]  mt  [64][2];
  logic [63:0] md  [64][2];
  int          mlru [64];     // least recently used way per set
  int          mbusy = 0;     // 0 none, 1 read pending on SRAM, 2 write pending
  logic [31:0] maddr, mwdata;

  task automatic model_lookup(input logic [31:0] a, output bit hit, output int way);
    hit = 0;
    way = 0;
    for (int w = 0; w < 2; w++) begin
      if (mv[a[8:3]][w] === 1'b1 && mt[a[8:3]][w] == a[18:9]) begin
        hit = 1;
        way = w;
      end
    end
  endtask

  task automatic model_step();
    logic        e_ready, e_ren, e_wen, chk_rd;
    logic [31:0] e_addr, e_wd, e_rd;
    bit          hit;
    int          way, s;
    e_ready = 0; e_ren = 0; e_wen = 0; chk_rd = 0;
    e_addr = '0; e_wd = '0; e_rd = '0;
    if (!rst) begin
      for (int i = 0; i < 64; i++) begin
        mv[i][0] = 0; mv[i][1] = 0; mlru[i] = 0;
      end
      mbusy = 0; e_ready = 1; chk_rd = 1;
    end else if (mbusy == 0) begin
      if (read_en) begin
        model_lookup(address, hit, way);
        if (hit) begin
          e_ready = 1; chk_rd = 1;
          e_rd = address[2] ? md[address[8:3]][way][63:32] : md[address[8:3]][way][31:0];
          mlru[address[8:3]] = 1 - way;
        end else begin
          e_ren = 1; e_addr = address & ~32'h7;
          mbusy = 1; maddr = address;
        end
      end else if (write_en) begin
        model_lookup(address, hit, way);
        e_wen = 1; e_addr = address; e_wd = write_data;
        if (hit) begin
          if (address[2]) md[address[8:3]][way][63:32] = write_data;
          else md[address[8:3]][way][31:0] = write_data;
          mlru[address[8:3]] = 1 - way;
        end
        mbusy = 2; maddr = address; mwdata = write_data;
      end else begin
        e_ready = 1;
      end
    end else if (mbusy == 1) begin
      e_ren = 1; e_addr = maddr & ~32'h7;
      if (sram_ready) begin
        e_ready = 1; chk_rd = 1;
        e_rd = maddr[2] ? sram_read_data[63:32] : sram_read_data[31:0];
        s = maddr[8:3];
        mv[s][mlru[s]] = 1; mt[s][mlru[s]] = maddr[18:9]; md[s][mlru[s]] = sram_read_data;
        mlru[s] = 1 - mlru[s];
        mbusy = 0;
      end
    end else begin
      e_wen = 1; e_addr = maddr; e_wd = mwdata;
      if (sram_ready) begin
        e_ready = 1;
        mbusy = 0;
      end
    end
    chk("ready", ready, e_ready);
    chk("sram_read_en", sram_read_en, e_ren);
    chk("sram_write_en", sram_write_en, e_wen);
    if (e_ren || e_wen) chk("sram_address", sram_address, e_addr);
    if (e_wen) chk("sram_write_data", sram_write_data, e_wd);
    if (chk_rd && (read_en || !rst)) chk("read_data", read_data, e_rd);
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      model_step();
    end
  endtask

  // ---------------- directed requests ----------------
  logic [31:0] r_data;
  int          r_cyc;
  logic        saw_ren, saw_wen;
  logic [31:0] last_saddr, last_swd;

  // Called at posedge+1; returns at posedge+1 with the request dropped.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
    address = a; write_data = wd; read_en = rd; write_en = wr;
    r_cyc = 0; r_data = '0; saw_ren = 0; saw_wen = 0;
    last_saddr = '0; last_swd = '0;
    forever begin
      @(negedge clk);
      r_cyc++;
      if (sram_read_en) begin saw_ren = 1; last_saddr = sram_address; end
      if (sram_write_en) begin saw_wen = 1; last_saddr = sram_address; last_swd = sram_write_data; end
      if (ready) begin
        r_data = read_data;
        break;
      end
      if (r_cyc >= 20) begin
        checks++; errors++;
        $display("FAIL timeout: no ready after %0d cycles for address %h", r_cyc, a);
        break;
      end
    end
    @(posedge clk);
    #1;
    read_en = 0; write_en = 0;
  endtask

  initial begin
    fork
      compare_loop();
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    @(posedge clk); #1;
    chk("reset ready", ready, 1);
    chk("reset read_data", read_data, 0);
    chk("reset sram_read_en", sram_read_en, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;

    // Cold miss on 0x404 fills way0, forwards the upper word
    do_req(1, 0, 32'h404, 0);
    chk("miss404 data", r_data, 32'hBBBBBBBB);
    chk("miss404 cycles", r_cyc, SRAM_LAT + 1);
    chk("miss404 sram addr", last_saddr, 32'h400);
    // Hit on the other word of the same block
    do_req(1, 0, 32'h400, 0);
    chk("hit400 data", r_data, 32'hAAAAAAAA);
    chk("hit400 cycles", r_cyc, 1);
    chk("hit400 no sram", saw_ren, 0);
    // 0x600 fills way1, then 0x400 hit makes way1 LRU, 0x800 evicts 0x600
    do_req(1, 0, 32'h600, 0);
    chk("miss600 data", r_data, 32'h0F0000C0);
    chk("miss600 cycles", r_cyc, SRAM_LAT + 1);
    do_req(1, 0, 32'h400, 0);
    chk("hit400b cycles", r_cyc, 1);
    do_req(1, 0, 32'h800, 0);
    chk("miss800 data", r_data, 32'h0F000100);
    chk("miss800 cycles", r_cyc, SRAM_LAT + 1);
    do_req(1, 0, 32'h400, 0);
    chk("hit400c cycles", r_cyc, 1);
    chk("hit400c data", r_data, 32'hAAAAAAAA);
    do_req(1, 0, 32'h600, 0);
    chk("remiss600 cycles", r_cyc, SRAM_LAT + 1);
    // Write hit updates SRAM and the cached word
    do_req(0, 1, 32'h404, 32'h12345678);
    chk("wr404 cycles", r_cyc, SRAM_LAT + 1);
    chk("wr404 sram data", last_swd, 32'h12345678);
    chk("wr404 sram addr", last_saddr, 32'h404);
    do_req(1, 0, 32'h404, 0);
    chk("rd404 after wr data", r_data, 32'h12345678);
    chk("rd404 after wr cycles", r_cyc, 1);
    // Read and write together act as a read
    do_req(1, 1, 32'h404, 32'hFFFFFFFF);
    chk("rw404 data", r_data, 32'h12345678);
    chk("rw404 no store", saw_wen, 0);
    // Write miss does not allocate
    do_req(0, 1, 32'h1000, 32'hDEADBEEF);
    chk("wr1000 cycles", r_cyc, SRAM_LAT + 1);
    do_req(1, 0, 32'h1000, 0);
    chk("rd1000 misses", r_cyc, SRAM_LAT + 1);
    chk("rd1000 data", r_data, 32'hDEADBEEF);

    // Reset in the middle of a miss aborts the fill
    address = 32'h2000; read_en = 1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("midrst ready", ready, 1);
    chk("midrst sram_read_en", sram_read_en, 0);
    chk("midrst sram_write_en", sram_write_en, 0);
    @(posedge clk); #1;
    read_en = 0;
    @(posedge clk); #1;
    rst = 1;
    do_req(1, 0, 32'h2000, 0);
    chk("rd2000 after reset misses", r_cyc, SRAM_LAT + 1);
    chk("rd2000 data", r_data, 32'h0F000400);
    do_req(1, 0, 32'h404, 0);
    chk("rd404 after reset misses", r_cyc, SRAM_LAT + 1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- 2-way set-associative, write-through, no-write-allocate data cache between the pipeline memory stage and the SRAM controller.
- Read hits return data in the same cycle with no SRAM traffic.
- Read misses fetch a 64-bit block (two words) from the SRAM controller and fill the LRU way.
- Writes always go to SRAM; on a hit, the cached word is updated as well.

Parameters:
- ADDRESS_LEN, 32, address width from the memory stage.
- DATA_LEN, 32, word width.
- SET_COUNT, 64, number of sets (index = address[8:3]).
- TAG_LEN, 10, tag width (tag = address[18:9]).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- address  in  ADDRESS_LEN  byte address from the memory stage.
- write_data  in  DATA_LEN  store data.
- read_en  in  1  load request, level; held until ready.
- write_en  in  1  store request, level; held until ready.
- read_data  out  DATA_LEN  load result, valid when ready=1 and read_en=1.
- ready  out  1  request complete; the pipeline freezes while 0.
- sram_address  out  ADDRESS_LEN  address to the SRAM controller.
- sram_write_data  out  DATA_LEN  store data to the SRAM controller.
- sram_read_data  in  2*DATA_LEN  block from SRAM; [31:0] is the word at block offset 0, [63:32] at offset 4.
- sram_write_en  out  1  SRAM write request.
- sram_read_en  out  1  SRAM read request.
- sram_ready  in  1  SRAM controller idle or finishing.

Behaviour:
- Address fields:
  - word select = address[2];
  - index = address[8:3];
  - tag = address[18:9];
  - address[1:0] ignored.
- Storage per set: two ways, each with valid, tag and 64-bit block; one LRU bit (0 = way0 least recent).
- Hit: valid & tag match in either way, evaluated combinationally from the current address.
- Precedence: read_en and write_en both high is treated as a read.
- FSM states: IDLE, READ_MISS, WRITE.
- IDLE:
  - read_en & hit: ready=1 same cycle; read_data = selected word of the hit way; LRU updated at the clock edge to point at the other way.
  - read_en & miss: ready=0; sram_read_en=1; sram_address = {address[31:3],3'b000}; next state READ_MISS.
  - write_en: ready=0; sram_write_en=1; sram_address = address; sram_write_data = write_data; next state WRITE.
    - On a hit, the selected word of the hit way is overwritten at this edge and LRU is updated.
    - On a miss, no allocation.
  - No request: ready=1; sram enables 0.
- READ_MISS:
  - sram_read_en held at 1 and address held until sram_ready=1.
  - In the sram_ready cycle: ready=1; read_data = selected word of sram_read_data (forwarded, not from the array).
  - At that edge: fill the LRU way (valid=1, tag, block); LRU now points at the other way; return to IDLE.
- WRITE:
  - sram_write_en held at 1 until sram_ready=1.
  - In that cycle ready=1; at that edge return to IDLE.
- sram_ready is sampled only in READ_MISS and WRITE. While IDLE is issuing a request it is ignored, because the SRAM controller drives it low combinationally when an enable is seen.
- The pipeline advances on the ready=1 edge, so the next cycle in IDLE sees a new request. A completed request is never re-issued.
- Request changes mid-miss are illegal (the pipeline is frozen); the block holds its latched state.
- Reset (rst=0, asynchronous):
  - state=IDLE;
  - all valid bits=0;
  - all LRU bits=0;
  - sram_read_en=0, sram_write_en=0;
  - ready=1, read_data=0.
- Reset asserted mid-miss aborts the fill; no line becomes valid.
- Tag and data arrays need no reset.

Decomposition:
- Shared constants package (extend Constants.v): CACHE_SET_COUNT, CACHE_TAG_LEN, index/tag bit positions, FSM state encodings (CACHE_IDLE, CACHE_READ_MISS, CACHE_WRITE).
- One sub-module, cache_memory: the valid/tag/data/LRU arrays with hit detection, fill and word-write ports.
- cache_controller itself contains the FSM and the SRAM handshake.

Test Plan:
- Reset, read 0x404; SRAM returns 0xBBBBBBBB_AAAAAAAA after 4 cycles -> sram_read_en=1 with sram_address 0x400 until sram_ready; read_data 0xBBBBBBBB and ready=1 in the sram_ready cycle.
- Read 0x400 after the previous fill -> ready=1 same cycle, read_data 0xAAAAAAAA, sram_read_en stays 0.
- Fill 0x400 (way0), then 0x600 (way1), then hit 0x400, then read 0x800 (all index 0) -> 0x800 evicts way1. A later 0x600 read misses; a 0x400 read hits.
- Write 0x404 data 0x12345678 on a hit -> sram_write_en=1, sram_write_data 0x12345678, ready=0 until sram_ready. A subsequent read 0x404 hits and returns 0x12345678.
- Write miss 0x1000 -> SRAM write issued; a following read 0x1000 misses (no allocation).
- rst=0 during READ_MISS, then release and re-read the same address -> sram enables 0 and ready=1 immediately on reset; the re-read misses again.
